// File: rtl/clock_ratio_meter_pkg.sv
// clock_ratio_meter_pkg: state encoding and default parameters shared by clock_ratio_meter.
package clock_ratio_meter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } state_e;
    localparam int DEF_COUNT_WIDTH = 32;
    localparam int DEF_TIMEOUT     = 65535;
endpackage

// File: rtl/clock_ratio_meter_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus history flop; reports level and single-cycle rise/fall.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1_q, s2_q, p_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) {s1_q, s2_q, p_q} <= '0;
        else {s1_q, s2_q, p_q} <= {d, s1_q, s2_q};
    assign level = s2_q;
    assign rise  = s2_q & ~p_q;
    assign fall  = ~s2_q & p_q;
endmodule

// File: rtl/clock_ratio_meter.sv
// clock_ratio_meter: measures period (and high time with CLOCK_RATIO_METER_DUTY_EN) of slow sig_in in clk cycles.
// Results are offered on a valid/ready handshake; timeout qualifies a result as abandoned.
module clock_ratio_meter
    import clock_ratio_meter_pkg::*;
#(
    parameter int                     COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter logic [COUNT_WIDTH-1:0] TIMEOUT     = COUNT_WIDTH'(DEF_TIMEOUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sig_in,
    input  logic                   start,
    output logic                   busy,
    output logic                   valid,
    input  logic                   ready,
    output logic [COUNT_WIDTH-1:0] period_out,
    output logic [COUNT_WIDTH-1:0] high_out,
    output logic                   timeout
);
    state_e                 state_q, state_d;
    logic                   level, rise, unused_fall, expire, done, abort;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc, period_q, period_d;
    logic                   timeout_q, timeout_d;

    sync_edge_detect u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .level(level),
        .rise (rise),
        .fall (unused_fall)
    );

    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + COUNT_WIDTH'(1);
    // expire fires on the cycle whose increment lands on TIMEOUT
    assign expire  = cnt_q >= TIMEOUT - COUNT_WIDTH'(1);
    assign done    = state_q == MEASURE && rise;
    assign abort   = busy && !rise && expire;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ARM;
            ARM:     state_d = rise ? MEASURE : expire ? HOLD : ARM;
            MEASURE: if (rise || expire) state_d = HOLD;
            HOLD:    if (ready) state_d = start ? ARM : IDLE;
        endcase
    end

    always_comb begin
        busy  = state_q == ARM || state_q == MEASURE;
        valid = state_q == HOLD;
    end

    always_comb begin
        cnt_d     = state_q == ARM && rise ? COUNT_WIDTH'(1) : busy ? cnt_inc : state_d == ARM ? '0 : cnt_q;
        period_d  = done ? cnt_q : abort ? '0 : period_q;
        timeout_d = done ? 1'b0 : abort ? 1'b1 : timeout_q;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt_q     <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
        end

    assign period_out = period_q;
    assign timeout    = timeout_q;

`ifdef CLOCK_RATIO_METER_DUTY_EN
    logic [COUNT_WIDTH-1:0] hcnt_q, hcnt_d, high_q, high_d;
    // the rise cycle itself is already high, hence the start value of 1
    always_comb begin
        hcnt_d = state_q == ARM && rise ? COUNT_WIDTH'(1)
               : state_q == MEASURE && level && !(&hcnt_q) ? hcnt_q + COUNT_WIDTH'(1) : hcnt_q;
        high_d = done ? hcnt_q : abort ? '0 : high_q;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    assign high_out = high_q;
`else
    logic unused_level;
    assign unused_level = level;
    assign high_out     = '0;
`endif
endmodule
